// File: rtl/rv32i_pkg.sv
// Shared RV32I front-end definitions: data width, NOP encoding, default
// reset PC and the {pc, instr} fetch-queue entry.
package rv32i_pkg;

   localparam int unsigned XLEN = 32;

   // ADDI x0, x0, 0
   localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   localparam int unsigned FETCH_ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush, used for both the PC tag queue and the fetch
// queue. DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// Ports:
//   clk, reset        clock, async active-high reset
//   flush             drop all entries (wins over push/pop)
//   push, push_data   write an entry
//   pop, pop_data     remove head entry; pop_data always shows the head
//   full, empty       occupancy flags
//   count             number of stored entries
module fetch_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push_c;
   logic             do_pop_c;

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign pop_data = mem[rd_ptr];

   // A push into a full queue is only legal when the head leaves that cycle.
   assign do_pop_c  = pop && !empty;
   assign do_push_c = push && (!full || do_pop_c);

   // Pointer and occupancy tracking
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push_c) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop_c)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push_c) - CW'(do_pop_c);
      end
   end

   // Storage needs no reset; contents are qualified by count
   always_ff @(posedge clk) begin
      if (do_push_c && !flush) mem[wr_ptr] <= push_data;
   end

   overflow_a: assert property (@(posedge clk) disable iff (reset)
                                !(push && full && !pop && !flush));

endmodule

// File: rtl/instr_fetch_unit.sv
// RV32I fetch stage. Owns the PC, issues in-order word requests under a
// credit limit of FIFO_DEPTH (queued + outstanding), buffers returned words
// with their PC and hands {instr, pc, pc+4} to decode. A redirect flushes
// both queues and arms a discard counter so stale responses are dropped.
// Ports:
//   clk, reset                  clock, async active-high reset
//   imem_req/addr/gnt           instruction memory request channel
//   imem_rvalid/rdata           in-order response channel
//   redirect, redirect_pc       taken branch/jump from execute
//   out_valid/ready             decode handshake
//   out_instr/pc/pc_plus4       decode payload (NOP when !out_valid)
module instr_fetch_unit
   import rv32i_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
   parameter int unsigned     FIFO_DEPTH = 2
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_instr,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_pc_plus4
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned SW = CW + 1;

   logic [XLEN-1:0] fetch_pc;
   logic [CW-1:0]   outstanding;
   logic [CW-1:0]   discard;

   logic [XLEN-1:0] tag_pc;
   logic [CW-1:0]   tag_count;
   logic            tag_full;
   logic            tag_empty;
   logic [CW-1:0]   q_count;
   logic            q_full;
   logic            q_empty;
   fetch_entry_t    head;
   fetch_entry_t    new_entry_c;

   logic issue_c;
   logic grant_c;
   logic keep_c;
   logic pop_c;
   logic unused_status;

   // Credit: never more words in flight plus buffered than the queue can hold
   assign issue_c = !reset && !redirect &&
                    ((SW'(q_count) + SW'(outstanding)) < SW'(FIFO_DEPTH));
   assign imem_req  = issue_c;
   assign imem_addr = fetch_pc;
   assign grant_c   = issue_c && imem_gnt;

   // Responses are kept only when no pre-redirect words remain to be dropped
   assign keep_c      = imem_rvalid && !redirect && (discard == '0);
   assign new_entry_c = '{pc: tag_pc, instr: imem_rdata};

   assign out_valid    = !q_empty && !redirect;
   assign pop_c        = out_valid && out_ready;
   assign out_instr    = out_valid ? head.instr : NOP_INSTR;
   assign out_pc       = head.pc;
   assign out_pc_plus4 = out_pc + 32'd4;

   assign unused_status = ^{tag_full, tag_empty, tag_count, q_full};

   // PC of each granted request, matched to responses in order
   fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(XLEN)) u_tag_q (
      .clk       (clk),
      .reset     (reset),
      .flush     (redirect),
      .push      (grant_c),
      .push_data (fetch_pc),
      .pop       (keep_c),
      .pop_data  (tag_pc),
      .full      (tag_full),
      .empty     (tag_empty),
      .count     (tag_count)
   );

   // Returned words awaiting decode
   fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(FETCH_ENTRY_W)) u_fetch_q (
      .clk       (clk),
      .reset     (reset),
      .flush     (redirect),
      .push      (keep_c),
      .push_data (new_entry_c),
      .pop       (pop_c),
      .pop_data  (head),
      .full      (q_full),
      .empty     (q_empty),
      .count     (q_count)
   );

   // PC, bus-outstanding and discard counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc    <= RESET_PC;
         outstanding <= '0;
         discard     <= '0;
      end else begin
         // Outstanding follows the bus even across redirects
         outstanding <= outstanding + CW'(grant_c) - CW'(imem_rvalid);
         if (redirect) begin
            fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
            discard  <= outstanding - CW'(imem_rvalid);
         end else begin
            if (grant_c) fetch_pc <= fetch_pc + 32'd4;
            if (imem_rvalid && (discard != '0)) discard <= discard - CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: random-latency in-order memory model plus a
// stream-level reference (expected fetch address, expected decode PC, and an
// epoch tag on every in-flight word so pre-redirect words count as stale).
module tb_instr_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;
   localparam int          DEPTH    = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic [31:0] out_pc_plus4;

   instr_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_gnt     (imem_gnt),
      .imem_rvalid  (imem_rvalid),
      .imem_rdata   (imem_rdata),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_instr    (out_instr),
      .out_pc       (out_pc),
      .out_pc_plus4 (out_pc_plus4)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   int unsigned gnt_pct, rv_pct, rdy_pct;
   logic [31:0] mem_q[$];
   int          mem_e[$];
   int          epoch;
   logic [31:0] exp_addr, exp_pc;

   int          first_grant_cyc, first_valid_cyc;
   int          grants_seen, xfers_seen;
   logic        arm_addr, arm_pc;
   logic [31:0] first_addr, first_pc;
   logic        wrap_xfer_seen, wrap_addr_seen;
   logic [31:0] prev_gaddr;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
   endfunction

   function automatic int live_in_mem();
      int n = 0;
      foreach (mem_e[i]) if (mem_e[i] == epoch) n++;
      return n;
   endfunction

   // Words of the current stream granted but not yet taken by decode
   function automatic int inflight();
      return int'((exp_addr - exp_pc) >> 2);
   endfunction

   task automatic model_reset();
      mem_q.delete();
      mem_e.delete();
      epoch++;
      exp_addr = RESET_PC;
      exp_pc   = RESET_PC;
   endtask

   // One clock cycle: drive, check against the model, clock, update the model
   task automatic tick();
      logic granted, xfer, exp_req, exp_valid;
      logic [31:0] gaddr;
      int live, stale, queued;
      imem_gnt = ($urandom_range(99) < gnt_pct);
      if (mem_q.size() > 0 && $urandom_range(99) < rv_pct) begin
         imem_rvalid = 1'b1;
         imem_rdata  = instr_of(mem_q[0]);
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = $urandom;
      end
      out_ready = ($urandom_range(99) < rdy_pct);
      #1;
      live      = live_in_mem();
      stale     = mem_q.size() - live;
      queued    = inflight() - live;
      exp_req   = !redirect && ((inflight() + stale) < DEPTH);
      exp_valid = !redirect && (queued > 0);
      total++;
      if (imem_req !== exp_req) begin
         bad++; $display("FAIL imem_req cyc=%0d: got %b want %b", cyc, imem_req, exp_req);
      end
      total++;
      if (out_valid !== exp_valid) begin
         bad++; $display("FAIL out_valid cyc=%0d: got %b want %b", cyc, out_valid, exp_valid);
      end
      if (!out_valid) begin
         total++;
         if (out_instr !== NOP) begin
            bad++; $display("FAIL nop cyc=%0d: got %h want %h", cyc, out_instr, NOP);
         end
      end
      granted = imem_req && imem_gnt;
      gaddr   = imem_addr;
      xfer    = out_valid && out_ready;
      if (granted) begin
         total++;
         if (gaddr !== exp_addr) begin
            bad++; $display("FAIL imem_addr cyc=%0d: got %h want %h", cyc, gaddr, exp_addr);
         end
         if (first_grant_cyc < 0) first_grant_cyc = cyc;
         if (arm_addr) begin first_addr = gaddr; arm_addr = 1'b0; end
         if (gaddr == 32'h0 && prev_gaddr == 32'hFFFF_FFFC) wrap_addr_seen = 1'b1;
         prev_gaddr = gaddr;
      end
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (xfer) begin
         total++;
         if (out_pc !== exp_pc) begin
            bad++; $display("FAIL out_pc cyc=%0d: got %h want %h", cyc, out_pc, exp_pc);
         end
         total++;
         if (out_instr !== instr_of(exp_pc)) begin
            bad++; $display("FAIL out_instr cyc=%0d: got %h want %h", cyc, out_instr, instr_of(exp_pc));
         end
         total++;
         if (out_pc_plus4 !== exp_pc + 32'd4) begin
            bad++; $display("FAIL out_pc_plus4 cyc=%0d: got %h want %h", cyc, out_pc_plus4, exp_pc + 32'd4);
         end
         if (arm_pc) begin first_pc = out_pc; arm_pc = 1'b0; end
         if (out_pc == 32'hFFFF_FFFC && out_pc_plus4 == 32'h0) wrap_xfer_seen = 1'b1;
      end
      @(posedge clk);
      #1;
      if (imem_rvalid) begin
         void'(mem_q.pop_front());
         void'(mem_e.pop_front());
      end
      if (granted) begin
         mem_q.push_back(gaddr);
         mem_e.push_back(epoch);
         exp_addr = exp_addr + 32'd4;
         grants_seen++;
      end
      if (xfer) begin
         exp_pc = exp_pc + 32'd4;
         xfers_seen++;
      end
      if (redirect) begin
         epoch++;
         exp_addr = {redirect_pc[31:2], 2'b00};
         exp_pc   = exp_addr;
      end
      cyc++;
   endtask

   task automatic set_rates(input int unsigned g, input int unsigned r, input int unsigned d);
      gnt_pct = g; rv_pct = r; rdy_pct = d;
   endtask

   task automatic do_redirect(input logic [31:0] target);
      redirect    = 1'b1;
      redirect_pc = target;
      arm_addr    = 1'b1; first_addr = 32'hDEAD_BEEF;
      arm_pc      = 1'b1; first_pc   = 32'hDEAD_BEEF;
      tick();
      redirect    = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", imem_req); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      total++; if (out_instr !== NOP) begin bad++; $display("FAIL reset_instr: got %h want %h", out_instr, NOP); end
      reset = 1'b0;
      model_reset();
      #1;
      total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL release_req: got %b want 1", imem_req); end
      total++; if (imem_addr !== RESET_PC) begin bad++; $display("FAIL release_addr: got %h want %h", imem_addr, RESET_PC); end
   endtask

   task automatic test_stream();
      set_rates(100, 100, 100);
      first_grant_cyc = -1; first_valid_cyc = -1; xfers_seen = 0;
      repeat (20) tick();
      total++;
      if (first_valid_cyc - first_grant_cyc !== 2) begin
         bad++; $display("FAIL first_latency: got %0d want 2", first_valid_cyc - first_grant_cyc);
      end
      // Steady state: two words per three cycles, first word out in cycle 2
      total++;
      if (xfers_seen !== 12) begin
         bad++; $display("FAIL stream_xfers: got %0d want 12", xfers_seen);
      end
   endtask

   task automatic test_stall();
      int exp_grants;
      set_rates(100, 100, 0);
      exp_grants  = DEPTH - (inflight() + mem_q.size() - live_in_mem());
      grants_seen = 0;
      repeat (10) tick();
      total++;
      if (grants_seen !== exp_grants) begin
         bad++; $display("FAIL stall_grants: got %0d want %0d", grants_seen, exp_grants);
      end
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL stall_req: got %b want 0", imem_req); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_valid: got %b want 1", out_valid); end
      set_rates(100, 100, 100);
      xfers_seen = 0;
      repeat (20) tick();
      total++;
      if (xfers_seen < DEPTH) begin
         bad++; $display("FAIL resume_xfers: got %0d want >=%0d", xfers_seen, DEPTH);
      end
   endtask

   task automatic fill_outstanding();
      set_rates(100, 0, 100);
      repeat (4) tick();
      total++;
      if (mem_q.size() !== DEPTH) begin
         bad++; $display("FAIL outstanding_fill: got %0d want %0d", mem_q.size(), DEPTH);
      end
   endtask

   task automatic test_redirect();
      fill_outstanding();
      do_redirect(32'h0000_0100);
      total++;
      if (imem_addr !== 32'h0000_0100) begin
         bad++; $display("FAIL redir_next_addr: got %h want 00000100", imem_addr);
      end
      set_rates(100, 100, 100);
      repeat (12) tick();
      total++; if (first_addr !== 32'h0000_0100) begin bad++; $display("FAIL redir_first_addr: got %h want 00000100", first_addr); end
      total++; if (first_pc !== 32'h0000_0100) begin bad++; $display("FAIL redir_first_pc: got %h want 00000100", first_pc); end
   endtask

   task automatic test_redirect_rvalid();
      fill_outstanding();
      set_rates(100, 100, 100);
      do_redirect(32'h0000_0300);
      repeat (12) tick();
      total++; if (first_pc !== 32'h0000_0300) begin bad++; $display("FAIL redir_rv_first_pc: got %h want 00000300", first_pc); end
   endtask

   task automatic test_align_wrap();
      set_rates(100, 100, 100);
      do_redirect(32'h0000_0203);
      repeat (8) tick();
      total++; if (first_addr !== 32'h0000_0200) begin bad++; $display("FAIL align_addr: got %h want 00000200", first_addr); end
      wrap_xfer_seen = 1'b0; wrap_addr_seen = 1'b0; prev_gaddr = '0;
      do_redirect(32'hFFFF_FFF0);
      repeat (16) tick();
      total++; if (wrap_addr_seen !== 1'b1) begin bad++; $display("FAIL wrap_addr: got %b want 1", wrap_addr_seen); end
      total++; if (wrap_xfer_seen !== 1'b1) begin bad++; $display("FAIL wrap_plus4: got %b want 1", wrap_xfer_seen); end
   endtask

   task automatic test_back_to_back();
      set_rates(100, 100, 100);
      do_redirect(32'h0000_0400);
      do_redirect(32'h0000_0800);
      repeat (12) tick();
      total++; if (first_addr !== 32'h0000_0800) begin bad++; $display("FAIL b2b_addr: got %h want 00000800", first_addr); end
      total++; if (first_pc !== 32'h0000_0800) begin bad++; $display("FAIL b2b_pc: got %h want 00000800", first_pc); end
   endtask

   task automatic test_reset_mid();
      set_rates(100, 100, 100);
      repeat (7) tick();
      #2;
      reset = 1'b1;
      #1;
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL async_req: got %b want 0", imem_req); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL async_valid: got %b want 0", out_valid); end
      imem_gnt = 1'b0; imem_rvalid = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      #1;
      total++; if (imem_addr !== RESET_PC) begin bad++; $display("FAIL restart_addr: got %h want %h", imem_addr, RESET_PC); end
      total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL restart_req: got %b want 1", imem_req); end
      xfers_seen = 0;
      repeat (20) tick();
      total++; if (xfers_seen < 1) begin bad++; $display("FAIL restart_xfers: got %0d want >=1", xfers_seen); end
   endtask

   task automatic test_random();
      logic [31:0] tgt;
      for (int blk = 0; blk < 15; blk++) begin
         set_rates($urandom_range(100, 30), $urandom_range(100, 30), $urandom_range(100, 20));
         for (int i = 0; i < 100; i++) begin
            if ($urandom_range(99) < 3) begin
               tgt = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
               do_redirect(tgt);
            end else begin
               tick();
            end
         end
      end
   endtask

   initial begin
      epoch = 0; arm_addr = 1'b0; arm_pc = 1'b0; prev_gaddr = '0;
      first_addr = '0; first_pc = '0; wrap_xfer_seen = 1'b0; wrap_addr_seen = 1'b0;
      grants_seen = 0; xfers_seen = 0; first_grant_cyc = -1; first_valid_cyc = -1;
      set_rates(100, 100, 100);
      test_reset();
      test_stream();
      test_stall();
      test_redirect();
      test_redirect_rvalid();
      test_align_wrap();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
